fxp_mul_arb: RTL and testbench

Round-robin arbiter that shares one fixed-point multiplier (`fxp_mul`) among NREQ requesters in the KF datapath. Each requester hands over an operand pair with a valid/ready handshake. The block schedules one multiply per cycle through a 2-stage pipeline and returns the aligned N-bit product with the requester ID and an overflow flag. Its main use is letting the predict/update sequencers share a single DSP-mapped multiplier.

---
 rtl/fxp_mul_arb_pkg.sv | 15 +
 rtl/fxp_mul_arb_mul.sv | 21 ++
 rtl/fxp_mul_arb_rr_arb.sv | 31 +++
 rtl/fxp_types.vh | 6 +
 rtl/fxp_mul_arb.sv | 123 ++++++++++++
 tb/tb_fxp_mul_arb.sv | 217 +++++++++++++++++++++
 6 files changed

// File: rtl/fxp_mul_arb_pkg.sv
// rtl/fxp_mul_arb_pkg.sv - default widths and ring helper for the shared multiplier arbiter
`include "fxp_types.vh"

package fxp_mul_arb_pkg;

  localparam int FXP_N_DEF    = `FXP_N;
  localparam int FXP_FRAC_DEF = `FXP_FRAC;
  localparam int NREQ_DEF     = 4;

  // Index following idx in a ring of n slots
  function automatic int ring_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/fxp_mul_arb_mul.sv
// rtl/fxp_mul_arb_mul.sv - combinational signed fixed-point multiplier with Q-aligned output
module fxp_mul #(
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [N-1:0]   o_y_trunc,
  output logic [2*N-1:0] o_y_full
);

  logic [2*N-1:0] w_a_ext;
  logic [2*N-1:0] w_b_ext;

  // Sign-extend to the product width so the low 2N bits are the exact signed product
  assign w_a_ext   = {{N{i_a[N-1]}}, i_a};
  assign w_b_ext   = {{N{i_b[N-1]}}, i_b};
  assign o_y_full  = w_a_ext * w_b_ext;
  assign o_y_trunc = o_y_full[FRAC+N-1:FRAC];

endmodule

// File: rtl/fxp_mul_arb_rr_arb.sv
// rtl/fxp_mul_arb_rr_arb.sv - rotating-priority arbiter: request vector + pointer to one-hot grant
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int w_j;

  // Scan from the farthest slot back to ptr so the nearest valid requester wins last
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = (int'(i_ptr) + k) % NREQ;
      if (((i_req >> w_j) & NREQ'(1)) != '0) begin
        o_gnt = NREQ'(1) << w_j;
        o_idx = IDW'(w_j);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fxp_types.vh
// rtl/fxp_types.vh - fixed-point Q format shared across the KF datapath
`ifndef FXP_TYPES_VH
`define FXP_TYPES_VH
`define FXP_N 16
`define FXP_FRAC 8
`endif

// File: rtl/fxp_mul_arb.sv
// rtl/fxp_mul_arb.sv - round-robin sharing of one fixed-point multiplier over a 2-stage pipeline
module fxp_mul_arb
  import fxp_mul_arb_pkg::*;
#(
  parameter int N    = FXP_N_DEF,
  parameter int FRAC = FXP_FRAC_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_y,
  output logic              rsp_ovf
);

  logic [IDW-1:0]  r_ptr;
  logic [N-1:0]    r_a1;
  logic [N-1:0]    r_b1;
  logic [IDW-1:0]  r_id1;
  logic            r_v1;
  logic [N-1:0]    r_y2;
  logic            r_ovf2;
  logic [IDW-1:0]  r_id2;
  logic            r_v2;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gidx;
  logic            w_any;
  logic            w_stall;
  logic            w_s1_free;
  logic            w_accept;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [N-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;
  logic [N-1:0]    w_y_trunc;
  logic [2*N-1:0]  w_y_full;
  logic [N-FRAC:0] w_upper;
  logic            w_ovf;
  logic            w_unused_low;

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  fxp_mul #(
    .N    (N),
    .FRAC (FRAC)
  ) u_mul (
    .i_a       (r_a1),
    .i_b       (r_b1),
    .o_y_trunc (w_y_trunc),
    .o_y_full  (w_y_full)
  );

  // S1 takes a new operand pair when empty or when it drains into S2 this cycle;
  // looking at the stall keeps one acceptance per cycle while the output flows
  assign w_stall   = r_v2 & ~rsp_ready;
  assign w_s1_free = ~r_v1 | ~w_stall;
  assign w_accept  = ~rst & w_any & w_s1_free;
  assign req_ready = w_accept ? w_gnt : '0;
  assign w_ptr_nxt = IDW'(ring_next(int'(w_gidx), NREQ));

  assign w_sel_a = N'(req_a >> (int'(w_gidx) * N));
  assign w_sel_b = N'(req_b >> (int'(w_gidx) * N));

  // Overflow when the bits above the kept window are not a pure sign extension
  assign w_upper      = w_y_full[2*N-1:FRAC+N-1];
  assign w_ovf        = ~(&w_upper | ~|w_upper);
  assign w_unused_low = &{1'b0, w_y_full[FRAC+N-2:0]};

  // Pipeline advance, operand capture and pointer rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_id1  <= '0;
      r_v1   <= 1'b0;
      r_y2   <= '0;
      r_ovf2 <= 1'b0;
      r_id2  <= '0;
      r_v2   <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_y2   <= w_y_trunc;
          r_ovf2 <= w_ovf;
          r_id2  <= r_id1;
        end
      end
      if (w_accept) begin
        r_a1  <= w_sel_a;
        r_b1  <= w_sel_b;
        r_id1 <= w_gidx;
        r_v1  <= 1'b1;
        r_ptr <= w_ptr_nxt;
      end else if (!w_stall) begin
        r_v1 <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_v2;
  assign rsp_id    = r_id2;
  assign rsp_y     = r_y2;
  assign rsp_ovf   = r_ovf2;

endmodule

// File: tb/tb_fxp_mul_arb.sv
// tb/tb_fxp_mul_arb.sv - directed self-checking bench for the shared multiplier arbiter
module tb_fxp_mul_arb;

  localparam int N    = 16;
  localparam int FRAC = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_y;
  logic              rsp_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  fxp_mul_arb #(
    .N    (N),
    .FRAC (FRAC),
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    tick; tick;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_y !== 16'h0000) begin n_bad++; $display("FAIL reset_y: got %h expected 0000", rsp_y); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
    n_cmp++; if (rsp_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", rsp_ovf); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    rst = 1'b0; req_valid = '0;
    tick;
  endtask

  task automatic test_basic;
    set_op(0, 16'h0180, 16'h0200); req_valid = 4'b0001; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL basic_ready: got %b expected 0001", req_ready); end
    tick; req_valid = '0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early: got %b expected 0", rsp_valid); end
    tick;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y, rsp_ovf} !== {1'b1, 2'd0, 16'h0300, 1'b0}) begin
      n_bad++; $display("FAIL basic_rsp: got v=%b id=%0d y=%h ovf=%b expected v=1 id=0 y=0300 ovf=0", rsp_valid, rsp_id, rsp_y, rsp_ovf); end
    tick;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_after: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_sign_floor;
    set_op(2, 16'hFF80, 16'h0300); req_valid = 4'b0100; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL sign_ready: got %b expected 0100", req_ready); end
    tick; set_op(2, 16'hFFFF, 16'h0080);
    tick; req_valid = '0;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y, rsp_ovf} !== {1'b1, 2'd2, 16'hFE80, 1'b0}) begin
      n_bad++; $display("FAIL sign_rsp: got v=%b id=%0d y=%h ovf=%b expected v=1 id=2 y=fe80 ovf=0", rsp_valid, rsp_id, rsp_y, rsp_ovf); end
    tick;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y, rsp_ovf} !== {1'b1, 2'd2, 16'hFFFF, 1'b0}) begin
      n_bad++; $display("FAIL floor_rsp: got v=%b id=%0d y=%h ovf=%b expected v=1 id=2 y=ffff ovf=0", rsp_valid, rsp_id, rsp_y, rsp_ovf); end
    tick;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL floor_after: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_overflow;
    set_op(3, 16'h7F00, 16'h0200); req_valid = 4'b1000; #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL ovf_ready: got %b expected 1000", req_ready); end
    tick; req_valid = '0;
    tick;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y, rsp_ovf} !== {1'b1, 2'd3, 16'hFE00, 1'b1}) begin
      n_bad++; $display("FAIL ovf_rsp: got v=%b id=%0d y=%h ovf=%b expected v=1 id=3 y=fe00 ovf=1", rsp_valid, rsp_id, rsp_y, rsp_ovf); end
    tick;
  endtask

  task automatic test_fairness;
    logic [1:0]  seq [6];
    logic [1:0]  prev;
    logic [18:0] exp_rsp;
    seq = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
    for (int i = 0; i < NREQ; i++) set_op(i, 16'((i + 1) << 8), 16'h0100);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++; if (req_ready !== (4'b0001 << (c % 4))) begin
        n_bad++; $display("FAIL fair_grant[%0d]: got %b expected %b", c, req_ready, 4'b0001 << (c % 4)); end
      tick;
      if (c >= 1) begin
        exp_rsp = {1'b1, 2'((c - 1) % 4), 16'((((c - 1) % 4) + 1) << 8)};
        n_cmp++; if ({rsp_valid, rsp_id, rsp_y} !== exp_rsp) begin
          n_bad++; $display("FAIL fair_rsp[%0d]: got %h expected %h", c, {rsp_valid, rsp_id, rsp_y}, exp_rsp); end
      end
    end
    prev = 2'd3;
    req_valid = 4'b1101;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (req_ready !== (4'b0001 << seq[k])) begin
        n_bad++; $display("FAIL skip_grant[%0d]: got %b expected %b", k, req_ready, 4'b0001 << seq[k]); end
      tick;
      exp_rsp = {1'b1, prev, 16'((int'(prev) + 1) << 8)};
      n_cmp++; if ({rsp_valid, rsp_id, rsp_y} !== exp_rsp) begin
        n_bad++; $display("FAIL skip_rsp[%0d]: got %h expected %h", k, {rsp_valid, rsp_id, rsp_y}, exp_rsp); end
      prev = seq[k];
    end
    req_valid = '0;
    tick;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd3, 16'h0400}) begin
      n_bad++; $display("FAIL skip_drain: got %h expected %h", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd3, 16'h0400}); end
    tick;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL skip_empty: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_backpressure;
    int acc;
    acc = 0;
    rsp_ready = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (req_ready !== 4'b0000) acc++;
      if (k >= 2) begin
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, req_ready); end
        n_cmp++; if ({rsp_valid, rsp_id, rsp_y, rsp_ovf} !== {1'b1, 2'd0, 16'h0100, 1'b0}) begin
          n_bad++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d y=%h expected v=1 id=0 y=0100", k, rsp_valid, rsp_id, rsp_y); end
      end
      tick;
    end
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL bp_accepts: got %0d expected 2", acc); end
    rsp_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_resume: got %b expected 0100", req_ready); end
    tick; req_valid = '0;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd1, 16'h0200}) begin
      n_bad++; $display("FAIL bp_drain1: got %h expected %h", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd1, 16'h0200}); end
    tick;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd2, 16'h0300}) begin
      n_bad++; $display("FAIL bp_drain2: got %h expected %h", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd2, 16'h0300}); end
    tick;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_midflight;
    set_op(0, 16'h0300, 16'h0100);
    set_op(1, 16'h0500, 16'h0100);
    set_op(2, 16'h0600, 16'h0100);
    rsp_ready = 1'b0; req_valid = 4'b0110; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_grant0: got %b expected 0010", req_ready); end
    tick; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_grant1: got %b expected 0100", req_ready); end
    tick;
    n_cmp++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) begin
      n_bad++; $display("FAIL mid_full: got v=%b id=%0d expected v=1 id=1", rsp_valid, rsp_id); end
    rst = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    tick;
    rst = 1'b0; req_valid = 4'b1001; rsp_ready = 1'b1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", rsp_valid); end
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
    tick; req_valid = '0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_ghost0: got %b expected 0", rsp_valid); end
    tick;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_y} !== {1'b1, 2'd0, 16'h0300}) begin
      n_bad++; $display("FAIL mid_post_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd0, 16'h0300}); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_ghost[%0d]: got %b expected 0", k, rsp_valid); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    test_reset;
    test_basic;
    test_sign_floor;
    test_overflow;
    test_fairness;
    test_backpressure;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
